// File: rtl/yuv_to_rgb_pipe.sv
// yuv_to_rgb_pipe: 3-stage YCbCr->RGB (BT.601/BT.709) with x/y pixel tagging.
// Optional YUV2RGB_CLIP_CNT_EN adds clip_cnt, a per-frame clamp counter.
module yuv_to_rgb_pipe #(
  parameter int DW    = 8,
  parameter int IMG_W = 320,
  parameter int IMG_H = 466,
  parameter int CW    = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic          s_sof,
  input  logic [DW-1:0] s_y,
  input  logic [DW-1:0] s_u,
  input  logic [DW-1:0] s_v,
  input  logic          mode,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [DW-1:0] m_r,
  output logic [DW-1:0] m_g,
  output logic [DW-1:0] m_b,
  output logic [CW-1:0] m_x,
  output logic [CW-1:0] m_yc,
  output logic          m_sof,
  output logic          m_eol
`ifdef YUV2RGB_CLIP_CNT_EN
  ,
  output logic [15:0]   clip_cnt
`endif
);

  localparam int IW = DW + 11;
  localparam logic [CW-1:0] XL = CW'(IMG_W - 1);
  localparam logic [CW-1:0] YL = CW'(IMG_H - 1);
  localparam logic signed [IW-1:0] RND  = IW'(128);
  localparam logic signed [IW-1:0] MAXV = IW'((1 << DW) - 1);

  function automatic logic [DW-1:0] sat(
    input logic signed [IW-1:0] s
  );
    logic signed [IW-1:0] t;
    t = (s + RND) >>> 8;
    if (t[IW-1])
      sat = '0;
    else if (t > MAXV)
      sat = '1;
    else
      sat = t[DW-1:0];
  endfunction

  logic w_en;
  logic w_xfer;

  assign w_en    = !m_valid | m_ready;
  assign s_ready = w_en;
  assign w_xfer  = s_valid & w_en;

  // sof overrides the running counters for the pixel it rides on
  logic [CW-1:0] r_x;
  logic [CW-1:0] r_y;
  logic [CW-1:0] w_tx;
  logic [CW-1:0] w_ty;

  assign w_tx = s_sof ? '0 : r_x;
  assign w_ty = s_sof ? '0 : r_y;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_x <= '0;
      r_y <= '0;
    end else if (w_xfer) begin
      if (w_tx == XL) begin
        r_x <= '0;
        r_y <= (w_ty == YL) ? '0 : w_ty + CW'(1);
      end else begin
        r_x <= w_tx + CW'(1);
        r_y <= w_ty;
      end
    end
  end

  logic signed [DW-1:0] w_cb;
  logic signed [DW-1:0] w_cr;
  logic signed [IW-1:0] w_cbx;
  logic signed [IW-1:0] w_crx;
  logic signed [IW-1:0] w_kr;
  logic signed [IW-1:0] w_kgb;
  logic signed [IW-1:0] w_kgr;
  logic signed [IW-1:0] w_kb;

  // U - 2^(DW-1) is just the MSB inverted in two's complement
  assign w_cb  = {~s_u[DW-1], s_u[DW-2:0]};
  assign w_cr  = {~s_v[DW-1], s_v[DW-2:0]};
  assign w_cbx = IW'(w_cb);
  assign w_crx = IW'(w_cr);
  assign w_kr  = mode ? IW'(403) : IW'(359);
  assign w_kgb = mode ? IW'(48)  : IW'(88);
  assign w_kgr = mode ? IW'(120) : IW'(183);
  assign w_kb  = mode ? IW'(475) : IW'(454);

  logic                 r1_v;
  logic signed [IW-1:0] r1_y;
  logic signed [IW-1:0] r1_pr;
  logic signed [IW-1:0] r1_pgb;
  logic signed [IW-1:0] r1_pgr;
  logic signed [IW-1:0] r1_pb;
  logic [CW-1:0]        r1_x;
  logic [CW-1:0]        r1_yc;
  logic                 r1_sof;
  logic                 r1_eol;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r1_v   <= 1'b0;
      r1_y   <= '0;
      r1_pr  <= '0;
      r1_pgb <= '0;
      r1_pgr <= '0;
      r1_pb  <= '0;
      r1_x   <= '0;
      r1_yc  <= '0;
      r1_sof <= 1'b0;
      r1_eol <= 1'b0;
    end else if (w_en) begin
      r1_v <= w_xfer;
      if (w_xfer) begin
        r1_y   <= $signed({{(IW-DW-8){1'b0}}, s_y, 8'b0});
        r1_pr  <= w_kr * w_crx;
        r1_pgb <= w_kgb * w_cbx;
        r1_pgr <= w_kgr * w_crx;
        r1_pb  <= w_kb * w_cbx;
        r1_x   <= w_tx;
        r1_yc  <= w_ty;
        r1_sof <= (w_tx == '0) && (w_ty == '0);
        r1_eol <= (w_tx == XL);
      end
    end
  end

  logic                 r2_v;
  logic signed [IW-1:0] r2_sr;
  logic signed [IW-1:0] r2_sg;
  logic signed [IW-1:0] r2_sb;
  logic [CW-1:0]        r2_x;
  logic [CW-1:0]        r2_yc;
  logic                 r2_sof;
  logic                 r2_eol;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r2_v   <= 1'b0;
      r2_sr  <= '0;
      r2_sg  <= '0;
      r2_sb  <= '0;
      r2_x   <= '0;
      r2_yc  <= '0;
      r2_sof <= 1'b0;
      r2_eol <= 1'b0;
    end else if (w_en) begin
      r2_v <= r1_v;
      if (r1_v) begin
        r2_sr  <= r1_y + r1_pr;
        r2_sg  <= r1_y - r1_pgb - r1_pgr;
        r2_sb  <= r1_y + r1_pb;
        r2_x   <= r1_x;
        r2_yc  <= r1_yc;
        r2_sof <= r1_sof;
        r2_eol <= r1_eol;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid <= 1'b0;
      m_r     <= '0;
      m_g     <= '0;
      m_b     <= '0;
      m_x     <= '0;
      m_yc    <= '0;
      m_sof   <= 1'b0;
      m_eol   <= 1'b0;
    end else if (w_en) begin
      m_valid <= r2_v;
      if (r2_v) begin
        m_r   <= sat(r2_sr);
        m_g   <= sat(r2_sg);
        m_b   <= sat(r2_sb);
        m_x   <= r2_x;
        m_yc  <= r2_yc;
        m_sof <= r2_sof;
        m_eol <= r2_eol;
      end
    end
  end

`ifdef YUV2RGB_CLIP_CNT_EN
  function automatic logic clp(
    input logic signed [IW-1:0] s
  );
    logic signed [IW-1:0] t;
    t   = (s + RND) >>> 8;
    clp = t[IW-1] || (t > MAXV);
  endfunction

  logic [1:0]  r_oclip;
  logic [1:0]  w_nclip;
  logic [15:0] w_add;

  assign w_nclip = {1'b0, clp(r2_sr)} +
                   {1'b0, clp(r2_sg)} +
                   {1'b0, clp(r2_sb)};
  assign w_add   = {14'd0, r_oclip};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_oclip  <= '0;
      clip_cnt <= '0;
    end else begin
      if (w_en && r2_v)
        r_oclip <= w_nclip;
      if (m_valid && m_ready) begin
        if (m_sof)
          clip_cnt <= w_add;
        else if (clip_cnt > 16'hFFFF - w_add)
          clip_cnt <= 16'hFFFF;
        else
          clip_cnt <= clip_cnt + w_add;
      end
    end
  end
`endif

endmodule

// File: tb/tb_yuv_to_rgb_pipe.sv
// tb_yuv_to_rgb_pipe: directed + streamed checks against a plain-arithmetic
// colour/coordinate model, with a scoreboard compare on every output transfer.
module tb_yuv_to_rgb_pipe;

  localparam int DW = 8;
  localparam int W  = 24;
  localparam int H  = 8;
  localparam int CW = 10;

  logic          clk     = 1'b0;
  logic          rst_n   = 1'b0;
  logic          s_valid = 1'b0;
  logic          s_sof   = 1'b0;
  logic          mode    = 1'b0;
  logic          m_ready = 1'b1;
  logic [DW-1:0] s_y     = '0;
  logic [DW-1:0] s_u     = '0;
  logic [DW-1:0] s_v     = '0;
  wire           s_ready;
  wire           m_valid;
  wire           m_sof;
  wire           m_eol;
  wire [DW-1:0]  m_r;
  wire [DW-1:0]  m_g;
  wire [DW-1:0]  m_b;
  wire [CW-1:0]  m_x;
  wire [CW-1:0]  m_yc;
`ifdef YUV2RGB_CLIP_CNT_EN
  wire [15:0]    clip_cnt;
`endif

  yuv_to_rgb_pipe #(
    .DW(DW), .IMG_W(W), .IMG_H(H), .CW(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .s_valid(s_valid), .s_ready(s_ready),
    .s_sof(s_sof),
    .s_y(s_y), .s_u(s_u), .s_v(s_v),
    .mode(mode),
    .m_valid(m_valid), .m_ready(m_ready),
    .m_r(m_r), .m_g(m_g), .m_b(m_b),
    .m_x(m_x), .m_yc(m_yc),
    .m_sof(m_sof), .m_eol(m_eol)
`ifdef YUV2RGB_CLIP_CNT_EN
    ,
    .clip_cnt(clip_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int rdy_mode = 0;
  int mx = 0;
  int my = 0;
  int exp_clip = 0;
  logic [45:0] q[$];
  int cq[$];

  wire [45:0] w_out = {m_r, m_g, m_b, m_x, m_yc, m_sof, m_eol};

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // {clip_count[1:0], R, G, B}
  function automatic logic [25:0] conv(input int y, input int u,
                                       input int v, input bit md);
    int s[3];
    int t;
    int c;
    int kr, kgb, kgr, kb;
    logic [7:0] o[3];
    kr  = md ? 403 : 359;
    kgb = md ? 48  : 88;
    kgr = md ? 120 : 183;
    kb  = md ? 475 : 454;
    s[0] = 256 * y + kr * (v - 128);
    s[1] = 256 * y - kgb * (u - 128) - kgr * (v - 128);
    s[2] = 256 * y + kb * (u - 128);
    c = 0;
    for (int i = 0; i < 3; i++) begin
      t = (s[i] + 128) >>> 8;
      if (t < 0) begin
        t = 0;
        c++;
      end else if (t > 255) begin
        t = 255;
        c++;
      end
      o[i] = t[7:0];
    end
    return {c[1:0], o[0], o[1], o[2]};
  endfunction

  always begin
    @(posedge clk);
    #1;
    if (rdy_mode == 1)
      m_ready = ($urandom_range(0, 3) != 0);
    else
      m_ready = 1'b1;
  end

  task automatic send(input int y, input int u, input int v,
                      input bit md, input bit sof);
    int n;
    int tx;
    int ty;
    logic [25:0] c;
    @(negedge clk);
    s_valid = 1'b1;
    s_y = 8'(y);
    s_u = 8'(u);
    s_v = 8'(v);
    mode = md;
    s_sof = sof;
    #1;
    n = 0;
    while (!s_ready && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!s_ready) begin
      chk("s_ready_timeout", s_ready, 1);
    end else begin
      c = conv(y, u, v, md);
      tx = sof ? 0 : mx;
      ty = sof ? 0 : my;
      q.push_back({c[23:0], 10'(tx), 10'(ty),
                   (tx == 0 && ty == 0), (tx == W - 1)});
      cq.push_back(int'(c[25:24]));
      if (tx == W - 1) begin
        mx = 0;
        my = (ty == H - 1) ? 0 : ty + 1;
      end else begin
        mx = tx + 1;
        my = ty;
      end
    end
    @(posedge clk);
  endtask

  task automatic send_rnd(input bit sof);
    send($urandom_range(0, 255), $urandom_range(0, 255),
         $urandom_range(0, 255), 1'($urandom_range(0, 1)), sof);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      s_valid = 1'b0;
      s_sof = 1'($urandom_range(0, 1));
    end
  endtask

  logic hold = 1'b0;
  bit cpend = 1'b0;
  logic [45:0] held;
  logic [45:0] e;
  int ec;

  always begin
    @(negedge clk);
    if (!rst_n) begin
      hold = 1'b0;
      cpend = 1'b0;
    end else begin
`ifdef YUV2RGB_CLIP_CNT_EN
      if (cpend)
        chk("clip_cnt", clip_cnt, 64'(exp_clip));
`endif
      cpend = 1'b0;
      if (hold)
        chk("hold_stable", {m_valid, w_out}, {1'b1, held});
      hold = m_valid && !m_ready;
      held = w_out;
      if (m_valid && m_ready) begin
        chk("out_expected", 64'(q.size() > 0), 1);
        if (q.size() > 0) begin
          e = q.pop_front();
          ec = cq.pop_front();
          chk("pixel", w_out, e);
          if (e[1])
            exp_clip = ec;
          else
            exp_clip = (exp_clip + ec > 65535) ? 65535 : exp_clip + ec;
          cpend = 1'b1;
        end
      end
    end
  end

  initial begin
    int w;
    rst_n = 1'b0;
    #1;
    chk("reset_m_valid", m_valid, 0);
    chk("reset_outputs", w_out, 0);
    chk("reset_s_ready", s_ready, 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    chk("model_grey", conv(128, 128, 128, 0), {2'd0, 24'h808080});
    chk("model_blk601", conv(0, 0, 0, 0), {2'd2, 8'd0, 8'd136, 8'd0});
    chk("model_blk709", conv(0, 0, 0, 1), {2'd2, 8'd0, 8'd84, 8'd0});
    chk("model_wht601", conv(255, 255, 255, 0),
        {2'd2, 8'd255, 8'd121, 8'd255});

    idle(4);
    send(128, 128, 128, 0, 0);
    #1 chk("lat_edge1", m_valid, 0);
    idle(1);
    @(posedge clk);
    #1 chk("lat_edge2", m_valid, 0);
    @(posedge clk);
    #1 chk("lat_edge3", m_valid, 1);
    chk("grey_rgb", {m_r, m_g, m_b}, 24'h808080);

    idle(2);
    send(0, 0, 0, 0, 0);
    send(0, 0, 0, 1, 0);
    send(0, 0, 0, 0, 0);
    #1 chk("toggle0", {m_r, m_g, m_b}, {8'd0, 8'd136, 8'd0});
    idle(1);
    @(posedge clk);
    #1 chk("toggle1", {m_r, m_g, m_b}, {8'd0, 8'd84, 8'd0});
    @(posedge clk);
    #1 chk("toggle2", {m_r, m_g, m_b}, {8'd0, 8'd136, 8'd0});

    send(255, 255, 255, 0, 0);
    idle(6);

    rdy_mode = 1;
    send_rnd(1'b1);
    for (int i = 1; i < 2 * W * H; i++) begin
      if ($urandom_range(0, 4) == 0)
        idle(1);
      send_rnd(1'b0);
    end
    idle(1);
    w = 0;
    while (q.size() > 0 && w < 5000) begin
      @(posedge clk);
      w++;
    end
    chk("stream_drain", 64'(q.size()), 0);

    rdy_mode = 0;
    idle(4);
    send_rnd(1'b1);
    for (int i = 0; i < 136; i++)
      send_rnd(1'b0);
    send_rnd(1'b1);
    send_rnd(1'b0);
    idle(1);
    @(posedge clk);
    #1 chk("midframe_sof", {m_valid, m_x, m_yc, m_sof},
           {1'b1, 10'd0, 10'd0, 1'b1});
    @(posedge clk);
    #1 chk("after_sof", {m_valid, m_x, m_yc, m_sof},
           {1'b1, 10'd1, 10'd0, 1'b0});

    idle(4);
    send_rnd(1'b0);
    send_rnd(1'b0);
    send_rnd(1'b0);
    #1 chk("inflight_valid", m_valid, 1);
    #2;
    rst_n = 1'b0;
    s_valid = 1'b0;
    #1 chk("async_rst_valid", m_valid, 0);
    chk("async_rst_out", w_out, 0);
    q.delete();
    cq.delete();
    mx = 0;
    my = 0;
    exp_clip = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1 chk("no_stale1", m_valid, 0);
    @(posedge clk);
    #1 chk("no_stale2", m_valid, 0);
    send(10, 20, 30, 0, 0);
    idle(1);
    w = 0;
    while (!m_valid && w < 10) begin
      @(posedge clk);
      #1;
      w++;
    end
    chk("post_rst_tag", {m_valid, m_x, m_yc, m_sof},
        {1'b1, 10'd0, 10'd0, 1'b1});
    idle(6);
    chk("final_queue", 64'(q.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/yuv_to_rgb_pipe.md
YUV_TO_RGB_PIPE -- requirements
Module: yuv_to_rgb_pipe

Interface
REQ-001 SHALL have parameter DW, default 8, meaning component bit width for Y/U/V/R/G/B (legal 8..10).
REQ-002 SHALL have parameter IMG_W, default 320, meaning pixels per line.
REQ-003 SHALL have parameter IMG_H, default 466, meaning lines per frame.
REQ-004 SHALL have parameter CW, default 10, meaning coordinate width; IMG_W-1 and IMG_H-1 must fit in CW bits.
REQ-005 clk  input  1  clock; all logic on rising edge.
REQ-006 rst_n  input  1  reset, asynchronous, active-low.
REQ-007 s_valid  input  1  input pixel valid.
REQ-008 s_ready  output  1  block can accept an input pixel.
REQ-009 s_sof  input  1  start of frame; the pixel carrying it is (0,0).
REQ-010 s_y, s_u, s_v  input  DW each  luma, Cb, Cr.
REQ-011 mode  input  1  coefficient set: 0 = BT.601, 1 = BT.709.
REQ-012 m_valid  output  1  output pixel valid.
REQ-013 m_ready  input  1  downstream accepts the output pixel.
REQ-014 m_r, m_g, m_b  output  DW each  RGB result.
REQ-015 m_x, m_yc  output  CW each  column and line of the output pixel.
REQ-016 m_sof, m_eol  output  1 each  pixel is (0,0); pixel is at column IMG_W-1.

Function
REQ-017 SHALL be a 3-stage pipeline (multiply, sum, round/clamp) that advances only when the global enable en = !m_valid | m_ready is high.
REQ-018 SHALL drive s_ready = en; an input transfer occurs when s_valid & s_ready are both high.
REQ-019 SHALL give a latency of exactly 3 clk from input transfer to m_valid with m_ready held high; throughput 1 pixel/clk.
REQ-020 SHALL hold m_* data, coordinates and flags stable while m_valid & !m_ready, with no pixel lost or duplicated.
REQ-021 SHALL sample mode per pixel at input transfer and carry it down the pipeline; a mid-stream change affects only later pixels.
REQ-022 SHALL use offset O = 2^(DW-1), Cb = U-O, Cr = V-O, signed, and internal width of at least DW+11 bits.
REQ-023 SHALL compute S_R = 256Y + kR*Cr, S_G = 256Y - kGb*Cb - kGr*Cr, S_B = 256Y + kB*Cb.
REQ-024 SHALL use BT.601 coefficients kR=359, kGb=88, kGr=183, kB=454.
REQ-025 SHALL use BT.709 coefficients kR=403, kGb=48, kGr=120, kB=475.
REQ-026 SHALL round as (S+128) >>> 8, then clamp below 0 to 0 and above 2^DW-1 to 2^DW-1.
REQ-027 SHALL keep x/y counters that advance on each input transfer: x wraps at IMG_W-1 to 0 with y+1; y wraps at IMG_H-1 to 0.
REQ-028 SHALL tag each pixel with the counter value at its transfer.
REQ-029 SHALL, when s_sof arrives with a transfer, tag that pixel (0,0) and continue at (1,0), overriding any counter state, including mid-frame.
REQ-030 SHALL ignore s_sof when no transfer occurs, and leave counters and pipeline unchanged when s_valid is low.

Reset
REQ-031 On rst_n low SHALL immediately clear m_valid, m_r/g/b, m_x, m_yc, m_sof, m_eol, all pipeline valids and counters to 0.
REQ-032 Reset mid-frame SHALL discard in-flight pixels; the first pixel after reset is tagged (0,0).

Configuration
REQ-033 With macro YUV2RGB_CLIP_CNT_EN defined, SHALL add output clip_cnt [15:0]: +1 per output transfer per component clamped (0..3 per pixel), saturating at 16'hFFFF, cleared to the transfer's clip count on each output transfer with m_sof=1, reset to 0.
REQ-034 Without YUV2RGB_CLIP_CNT_EN, the clip_cnt port and its logic SHALL be absent; all other behaviour is identical.

Verification
REQ-035 DW=8, mode=0, Y=U=V=128, m_ready=1 -> R=G=B=128 exactly 3 clk after transfer.
REQ-036 DW=8, Y=U=V=0: mode=0 -> R=0,G=136,B=0; mode=1 -> R=0,G=84,B=0; toggling mode per pixel yields the per-pixel result.
REQ-037 DW=8, Y=255, U=V=255, mode=0 -> R=255 (clamped), B=255; with YUV2RGB_CLIP_CNT_EN, clip_cnt increments by the clamped-component count.
REQ-038 Stream 2*IMG_W*IMG_H pixels with random m_ready -> output sequence equals a reference model; the m_valid&!m_ready output stays stable; m_eol at every x=IMG_W-1; m_sof once per frame; coordinates wrap (IMG_W-1,IMG_H-1)->(0,0).
REQ-039 s_sof at pixel (17,5) -> that pixel tagged (0,0) with m_sof=1, next pixel (1,0).
REQ-040 Assert rst_n low with 3 pixels in flight -> m_valid=0 at once, no stale pixel after release, first new pixel tagged (0,0).
